canny_nms_pair: RTL
===================

# canny_nms_pair

Non-maximum-suppression stage of the Canny pipeline. It consumes the Sobel magnitude/direction stream at two pixels per clock and produces the thinned edge image in the two-pixels-per-clock RGB888 pair format taken by the BMP writer. It buffers two image rows, evaluates a 3x3 window per pixel, and drains its pipeline at frame end.

## Interface
- WIDTH, 768: image width in pixels; must be even and at least 4.
- HEIGHT, 512: image height in rows; must be at least 3.
- THRESH, 40: edge threshold; used only when CANNY_NMS_THRESH_EN is defined.
- HCLK  in  1  clock; all logic on posedge.
- HRESETn  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair strobe; one pair accepted per cycle while high.
- MAG0 / MAG1  in  8 each  gradient magnitude of the even / odd pixel of the pair.
- DIR0 / DIR1  in  2 each  quantised gradient direction, even / odd pixel.
- hsync  out  1  output pair valid; one cycle per pair.
- DATA_WRITE_R0/G0/B0  out  8 each  even output pixel.
- DATA_WRITE_R1/G1/B1  out  8 each  odd output pixel.
- frame_done  out  1  one-cycle pulse after the last output pair.

## Operation
- Input is raster order: row 0 first, WIDTH/2 pairs per row. Pair index k = r*(WIDTH/2)+m covers pixels 2m (MAG0) and 2m+1 (MAG1) of row r.
- No backpressure. Gaps in in_valid are allowed and stall the pipeline.
- States:
  - RUN (after reset): accepts pairs.
  - FLUSH: entered the cycle after input pair N-1 is accepted, where N = WIDTH*HEIGHT/2.
  - DONE: entered the cycle after the last flush output.
- Output pair k is emitted one cycle after input pair k+D is accepted, where D = WIDTH/2+1.
- In FLUSH, the remaining D output pairs are emitted on consecutive cycles; in_valid is ignored.
- In DONE, in_valid is ignored, hsync stays 0 and frame_done pulses once. DONE is held until reset.
- Directions: 0 compares left/right, 1 compares up-right/down-left, 2 compares up/down, 3 compares up-left/down-right.
- A pixel is kept if its magnitude is >= both compared neighbours (ties keep); otherwise it outputs 0.
- Border pixels output 0: row 0, row HEIGHT-1, column 0 and column WIDTH-1.
- Kept value v is replicated: R=G=B=v for each pixel of the pair.
- Pair counter is 18 bits (max index 196607 at defaults). Flush counter is sized for D.
- Line storage: two rows of 16-bit magnitude pairs plus direction, plus column-neighbour registers. Storage is not reset, and no stored value is output before it is written.

## Timing
- Reset values: hsync=0, frame_done=0, all DATA_WRITE_*=0, state RUN, all counters 0.
- Reset asserted mid-frame returns to RUN at once; the partial frame is discarded.
- Latency: the first hsync occurs the cycle after the (D+1)th accepted input.
- Data outputs are registered and change only with hsync=1; otherwise they hold their last value.
- Exactly N hsync pulses occur per frame.
- frame_done is high the cycle after the final hsync.
- Input accepted on the same cycle the state changes to FLUSH (pair N-1) counts normally.

## Configuration
- CANNY_NMS_THRESH_EN defined: a kept pixel outputs 255 if its magnitude >= THRESH, else 0. Suppressed and border pixels output 0.
- Not defined: a kept pixel outputs its raw magnitude. THRESH is unused.

## Test plan
- WIDTH=8, HEIGHT=4, all MAG=0x10, DIR=0, continuous in_valid:
  - interior pixels output 0x10 (tie keeps), borders 0;
  - 16 hsync pulses;
  - first hsync the cycle after the 6th input;
  - frame_done the cycle after the last hsync.
- Same size, single pixel (r1, c3)=0x80, rest 0x20, DIR=2 everywhere:
  - (1,3) outputs 0x80;
  - (2,3) is suppressed and outputs 0.
- Interior diagonal check, DIR=1 at (2,2)=0x50, (1,3)=0x60, others 0x10: (2,2) outputs 0.
- Same input as the diagonal check, DIR=3 at (2,2): (2,2) outputs 0x50.
- in_valid toggled every other cycle: output data is identical to the continuous run, and hsync gaps track the input gaps until FLUSH.
- HRESETn pulsed after 7 inputs, then a full frame:
  - outputs zero during reset;
  - the new frame matches a clean run;
  - with CANNY_NMS_THRESH_EN and THRESH=0x40, kept 0x50 gives 255 and kept 0x20 gives 0.

Source files
------------

// File: rtl/canny_nms_pair_if.sv
// canny_nms_pair_if
//   Bundles the magnitude/direction pair stream that enters the NMS stage and
//   the RGB888 pair stream that leaves it.
//
//   Handshake: valid-only streams with no ready/backpressure. A pair is
//   transferred on every rising HCLK edge where its strobe (in_valid on the
//   input side, hsync on the output side) is high. The receiver must take it
//   on that edge.
//
//   Signals
//     in_valid                 input pair strobe
//     MAG0 / MAG1              gradient magnitude, even / odd pixel
//     DIR0 / DIR1              quantised gradient direction, even / odd pixel
//     hsync                    output pair strobe
//     DATA_WRITE_R0/G0/B0      even output pixel
//     DATA_WRITE_R1/G1/B1      odd output pixel
//     frame_done               one-cycle pulse after the last output pair
//
//   Modports
//     master : stream source / sink (drives the input side)
//     slave  : the NMS stage (drives the output side)
interface canny_nms_pair_if;
    logic       in_valid;
    logic [7:0] MAG0;
    logic [7:0] MAG1;
    logic [1:0] DIR0;
    logic [1:0] DIR1;

    logic       hsync;
    logic [7:0] DATA_WRITE_R0;
    logic [7:0] DATA_WRITE_G0;
    logic [7:0] DATA_WRITE_B0;
    logic [7:0] DATA_WRITE_R1;
    logic [7:0] DATA_WRITE_G1;
    logic [7:0] DATA_WRITE_B1;
    logic       frame_done;

    modport master (
        output in_valid, MAG0, MAG1, DIR0, DIR1,
        input  hsync,
        input  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        input  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
        input  frame_done
    );

    modport slave (
        input  in_valid, MAG0, MAG1, DIR0, DIR1,
        output hsync,
        output DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        output DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
        output frame_done
    );
endinterface

// File: rtl/canny_nms_pair.sv
// canny_nms_pair
//   Non-maximum-suppression stage of the Canny pipeline, two pixels per clock.
//   A shift line of WIDTH+2 pairs (two image rows plus two column-neighbour
//   pairs) holds the history needed for a 3x3 window around each pixel of
//   the centre pair. Output pair k is produced when input pair k+D arrives
//   (D = WIDTH/2+1), because that input carries the down-right neighbour of
//   the odd pixel of pair k. At frame end D flush steps drain the line.
//
//   Optional feature macro: CANNY_NMS_THRESH_EN
//     defined     : a kept pixel outputs 255 if magnitude >= THRESH, else 0
//     not defined : a kept pixel outputs its raw magnitude
//
//   Ports
//     HCLK       clock, all logic on the rising edge
//     HRESETn    asynchronous active-low reset
//     bus        canny_nms_pair_if.slave (input pair stream, RGB pair output)
//     dbg_state  current FSM state (0 RUN, 1 FLUSH, 2 DONE)
module canny_nms_pair #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int THRESH = 40
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    canny_nms_pair_if.slave        bus,
    output logic [1:0]             dbg_state
);
    localparam int HALF  = WIDTH / 2;
    localparam int D     = HALF + 1;
    localparam int N     = WIDTH * HEIGHT / 2;
    localparam int DEPTH = WIDTH + 2;
    localparam int CNT_W = $clog2(N + 1);
    localparam int FL_W  = $clog2(D + 1);
    localparam int COL_W = $clog2(HALF + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4 || HEIGHT < 3 || THRESH < 0 || THRESH > 255)
    begin : g_param_check
        $error("canny_nms_pair: unsupported WIDTH/HEIGHT/THRESH");
    end

`ifdef CANNY_NMS_THRESH_EN
    localparam logic [7:0] THRESH_V = 8'(THRESH);
`endif

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] mag0;
        logic [7:0] mag1;
        logic [1:0] dir0;
        logic [1:0] dir1;
    } pair_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   in_cnt;
    logic [FL_W-1:0]    flush_cnt;
    logic [COL_W-1:0]   out_col;
    logic [ROW_W-1:0]   out_row;

    pair_t              hist [DEPTH];
    pair_t              cur;

    logic               accept;
    logic               flush_step;
    logic               shift_en;
    logic               emit;
    logic               last_in;
    logic               row_border;
    logic [7:0]         pix0;
    logic [7:0]         pix1;

    // 3x4 magnitude window: rows top/mid/bot (r-1, r, r+1), columns
    // 2m-1 .. 2m+2 around the centre pair m.
    logic [7:0] t0, t1, t2, t3;
    logic [7:0] m0, m1, m2, m3;
    logic [7:0] b0, b1, b2, b3;

    assign dbg_state = state_q;

    assign accept     = (state_q == S_RUN) && bus.in_valid;
    assign flush_step = (state_q == S_FLUSH) && (flush_cnt < FL_W'(D));
    assign shift_en   = accept || flush_step;
    assign emit       = (accept && (in_cnt >= CNT_W'(D))) || flush_step;
    assign last_in    = accept && (in_cnt == CNT_W'(N - 1));

    // During flush the line is fed zeros; every value they reach is a
    // border pixel or a neighbour of one, so they never appear at the output.
    always_comb begin
        cur = '0;
        if (state_q == S_RUN) begin
            cur.mag0 = bus.MAG0;
            cur.mag1 = bus.MAG1;
            cur.dir0 = bus.DIR0;
            cur.dir1 = bus.DIR1;
        end
    end

    // hist[i] holds the pair accepted i+1 shifts ago. Not reset: border
    // masking guarantees nothing is output before it has been written.
    always_ff @(posedge HCLK) begin
        if (shift_en) begin
            hist[0] <= cur;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    assign t0 = hist[2*HALF+1].mag1;
    assign t1 = hist[2*HALF].mag0;
    assign t2 = hist[2*HALF].mag1;
    assign t3 = hist[2*HALF-1].mag0;
    assign m0 = hist[HALF+1].mag1;
    assign m1 = hist[HALF].mag0;
    assign m2 = hist[HALF].mag1;
    assign m3 = hist[HALF-1].mag0;
    assign b0 = hist[1].mag1;
    assign b1 = hist[0].mag0;
    assign b2 = hist[0].mag1;
    assign b3 = cur.mag0;

    function automatic logic [7:0] nms_pixel(
        input logic [7:0] ul, input logic [7:0] u,  input logic [7:0] ur,
        input logic [7:0] l,  input logic [7:0] c,  input logic [7:0] r,
        input logic [7:0] dl, input logic [7:0] d,  input logic [7:0] dr,
        input logic [1:0] dir,
        input logic       border
    );
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] v;
        case (dir)
            2'd0:    begin a = l;  b = r;  end
            2'd1:    begin a = ur; b = dl; end
            2'd2:    begin a = u;  b = d;  end
            default: begin a = ul; b = dr; end
        endcase
`ifdef CANNY_NMS_THRESH_EN
        v = (c >= THRESH_V) ? 8'hFF : 8'h00;
`else
        v = c;
`endif
        // Ties keep the pixel.
        if (border || (c < a) || (c < b)) begin
            v = 8'h00;
        end
        return v;
    endfunction

    assign row_border = (out_row == '0) || (out_row == ROW_W'(HEIGHT - 1));

    assign pix0 = nms_pixel(t0, t1, t2, m0, m1, m2, b0, b1, b2, hist[HALF].dir0,
                            row_border || (out_col == '0));
    assign pix1 = nms_pixel(t1, t2, t3, m1, m2, m3, b1, b2, b3, hist[HALF].dir1,
                            row_border || (out_col == COL_W'(HALF - 1)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (last_in) state_d = S_FLUSH;
            // flush_cnt reaching D is the cycle showing the last flush pair.
            S_FLUSH: if (flush_cnt == FL_W'(D)) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q            <= S_RUN;
            in_cnt             <= '0;
            flush_cnt          <= '0;
            out_col            <= '0;
            out_row            <= '0;
            bus.hsync          <= 1'b0;
            bus.frame_done     <= 1'b0;
            bus.DATA_WRITE_R0  <= '0;
            bus.DATA_WRITE_G0  <= '0;
            bus.DATA_WRITE_B0  <= '0;
            bus.DATA_WRITE_R1  <= '0;
            bus.DATA_WRITE_G1  <= '0;
            bus.DATA_WRITE_B1  <= '0;
        end else begin
            state_q        <= state_d;
            bus.hsync      <= emit;
            bus.frame_done <= (state_q == S_FLUSH) && (state_d == S_DONE);

            if (accept) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (state_q == S_FLUSH && flush_cnt < FL_W'(D)) begin
                flush_cnt <= flush_cnt + FL_W'(1);
            end

            if (emit) begin
                bus.DATA_WRITE_R0 <= pix0;
                bus.DATA_WRITE_G0 <= pix0;
                bus.DATA_WRITE_B0 <= pix0;
                bus.DATA_WRITE_R1 <= pix1;
                bus.DATA_WRITE_G1 <= pix1;
                bus.DATA_WRITE_B1 <= pix1;
                if (out_col == COL_W'(HALF - 1)) begin
                    out_col <= '0;
                    out_row <= out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end
        end
    end
endmodule
